// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl
// Parses 4-byte register-write frames (A5, ADDR, DATA, CHK) from a UART byte
// stream, issues a one-cycle write strobe on a good checksum, flags checksum
// errors and inter-byte timeouts, and keeps saturating good/error counters.
module uart_frame_ctrl #(
   parameter int CLK           = 100_000_000,
   parameter int BPS           = 9600,
   parameter int TIMEOUT_BYTES = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_flag,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy,
   output logic       err_chk,
   output logic       err_timeout,
   output logic [7:0] ok_cnt,
   output logic [7:0] err_cnt
);

   localparam int TIMEOUT_CYC = TIMEOUT_BYTES * 10 * (CLK / BPS);
   // Guard the degenerate 1-cycle case so the counter is never zero bits wide.
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TERM = TW'(TIMEOUT_CYC - 1);

   localparam logic [7:0] HDR = 8'hA5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_CHK  = 2'd3
   } state_t;

   state_t          r_state;
   logic [TW-1:0]   r_tcnt;
   logic [7:0]      r_addr;
   logic [7:0]      r_data;
   logic [7:0]      w_chk;

   assign w_chk = HDR ^ r_addr ^ r_data;
   assign busy  = (r_state != S_IDLE);

   // Frame FSM, timeout counter, registered strobes and saturating counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_tcnt      <= '0;
         r_addr      <= 8'h00;
         r_data      <= 8'h00;
         wr_en       <= 1'b0;
         wr_addr     <= 8'h00;
         wr_data     <= 8'h00;
         err_chk     <= 1'b0;
         err_timeout <= 1'b0;
         ok_cnt      <= 8'h00;
         err_cnt     <= 8'h00;
      end else begin
         wr_en       <= 1'b0;
         err_chk     <= 1'b0;
         err_timeout <= 1'b0;
         if (rx_flag) begin
            // A byte always wins over a coincident terminal count.
            r_tcnt <= '0;
            case (r_state)
               S_IDLE: begin
                  if (rx_data == HDR) begin
                     r_state <= S_ADDR;
                  end
               end
               S_ADDR: begin
                  r_addr  <= rx_data;
                  r_state <= S_DATA;
               end
               S_DATA: begin
                  r_data  <= rx_data;
                  r_state <= S_CHK;
               end
               S_CHK: begin
                  r_state <= S_IDLE;
                  if (rx_data == w_chk) begin
                     wr_en   <= 1'b1;
                     wr_addr <= r_addr;
                     wr_data <= r_data;
                     if (ok_cnt != 8'hFF) begin
                        ok_cnt <= ok_cnt + 8'd1;
                     end
                  end else begin
                     err_chk <= 1'b1;
                     if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end else if (r_state == S_IDLE) begin
            r_tcnt <= '0;
         end else if (r_tcnt == TERM) begin
            // Gap too long: abandon the partial frame.
            r_state     <= S_IDLE;
            r_tcnt      <= '0;
            err_timeout <= 1'b1;
            if (err_cnt != 8'hFF) begin
               err_cnt <= err_cnt + 8'd1;
            end
         end else begin
            r_tcnt <= r_tcnt + 1'b1;
         end
      end
   end

endmodule
